sort_accel_slave_driver: RTL and testbench

- Synthesizable driver that sits directly upstream of the HLS-generated sort accelerator top (`main`) and connects to its slave memory port.
- Loads an input element stream into accelerator memory, pulses `start_port`, and waits for `done_port` while counting cycles.
- Then reads the result array back through the same slave port, streams it out, and flags any ordering violation or timeout.
- Replaces the tied-off slave port used in simulation, so on-board runs report pass/fail and cycle count.

---
 rtl/sort_accel_slave_driver.sv | 154 +++++++++++++++
 tb/tb_sort_accel_slave_driver.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sort_accel_slave_driver.sv
// Loads an element stream into the sort accelerator through its slave port, starts it,
// times the run, then reads the result back, streams it out and flags ordering errors.
module sort_accel_slave_driver #(
  parameter int N_ELEM      = 32,
  parameter int ADDR_W      = 7,
  parameter int DATA_W      = 8,
  parameter int SIZE_W      = 4,
  parameter int BASE_ADDR   = 0,
  parameter int TIMEOUT_CYC = 200000000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [DATA_W-1:0]     in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic                  out_last,
  input  logic                  out_ready,
  output logic [1:0]            S_oe_ram,
  output logic [1:0]            S_we_ram,
  output logic [2*ADDR_W-1:0]   S_addr_ram,
  output logic [2*DATA_W-1:0]   S_Wdata_ram,
  output logic [2*SIZE_W-1:0]   S_data_ram_size,
  input  logic [2*DATA_W-1:0]   Sout_Rdata_ram,
  input  logic [1:0]            Sout_DataRdy,
  output logic                  start_port,
  input  logic                  done_port,
  output logic [31:0]           cycles,
  output logic                  sorted_err,
  output logic                  timeout,
  output logic                  busy,
  output logic [3:0]            state_dbg
);

  // Handshakes: a transfer happens on the rising edge where valid and ready are both high;
  // valid never waits for ready, and data is held stable while valid is high and ready is low.

  typedef enum logic [3:0] {
    S_IDLE, S_WR_REQ, S_WR_WAIT, S_WR_ACC, S_START, S_RUN, S_RD_REQ, S_RD_WAIT, S_EMIT
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(N_ELEM - 1);
  localparam logic [32:0]       TIMEOUT_LIM = 33'(TIMEOUT_CYC);

  state_t              state, state_n;
  logic [ADDR_W-1:0]   idx, idx_n;
  logic [ADDR_W-1:0]   addr_n;
  logic [DATA_W-1:0]   rdata_q, prev_q, wdata_q;
  logic [31:0]         cycles_q;
  logic                err_q, timeout_q;
  logic                we_q, oe_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [SIZE_W-1:0]   size_q;
  logic                rdy, is_last, in_fire, out_fire, run_expire;
  logic                unused_inputs;

  assign rdy        = Sout_DataRdy[0];
  assign is_last    = (idx == LAST_IDX);
  assign in_ready   = (state == S_IDLE) || (state == S_WR_ACC);
  assign in_fire    = in_valid && in_ready;
  assign out_valid  = (state == S_EMIT);
  assign out_fire   = out_valid && out_ready;
  assign run_expire = ({1'b0, cycles_q} + 33'd1) >= TIMEOUT_LIM;
  assign addr_n     = ADDR_W'(32'(BASE_ADDR) + 32'(idx_n) * 32'(DATA_W / 8));
  assign unused_inputs = ^{Sout_Rdata_ram[2*DATA_W-1:DATA_W], Sout_DataRdy[1]};

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      S_IDLE:    if (in_fire) begin state_n = S_WR_REQ; idx_n = '0; end
      S_WR_REQ:  state_n = S_WR_WAIT;
      S_WR_WAIT: if (rdy) begin
                   if (is_last) state_n = S_START;
                   else begin idx_n = idx + 1'b1; state_n = S_WR_ACC; end
                 end
      S_WR_ACC:  if (in_fire) state_n = S_WR_REQ;
      S_START:   state_n = S_RUN;
      S_RUN:     if (done_port) begin idx_n = '0; state_n = S_RD_REQ; end
                 else if (run_expire) state_n = S_IDLE;
      S_RD_REQ:  state_n = S_RD_WAIT;
      S_RD_WAIT: if (rdy) state_n = S_EMIT;
      S_EMIT:    if (out_fire) begin
                   if (is_last) state_n = S_IDLE;
                   else begin idx_n = idx + 1'b1; state_n = S_RD_REQ; end
                 end
      default:   state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      rdata_q   <= '0;
      prev_q    <= '0;
      cycles_q  <= '0;
      err_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if (state == S_IDLE && in_fire) begin
        cycles_q  <= '0;
        err_q     <= 1'b0;
        timeout_q <= 1'b0;
      end
      if (state == S_START) cycles_q <= '0;
      // The done cycle itself is still counted; the count freezes once RUN is left.
      if (state == S_RUN) begin
        if (cycles_q != '1) cycles_q <= cycles_q + 32'd1;
        if (!done_port && run_expire) timeout_q <= 1'b1;
      end
      if (state == S_RD_WAIT && rdy) rdata_q <= Sout_Rdata_ram[DATA_W-1:0];
      if (out_fire) begin
        prev_q <= rdata_q;
        if (idx != '0 && rdata_q < prev_q) err_q <= 1'b1;
      end
    end
  end

  // Slave-side outputs are flops loaded from the next state so they line up with REQ/WAIT.
  always_ff @(posedge clock) begin
    if (reset) begin
      we_q    <= 1'b0;
      oe_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
    end else begin
      we_q   <= (state_n == S_WR_REQ);
      oe_q   <= (state_n == S_RD_REQ);
      size_q <= (state_n inside {S_WR_REQ, S_WR_WAIT, S_RD_REQ, S_RD_WAIT}) ? SIZE_W'(DATA_W) : '0;
      if (state_n == S_WR_REQ || state_n == S_RD_REQ) addr_q <= addr_n;
      if (state_n == S_WR_REQ) wdata_q <= in_data;
    end
  end

  assign S_we_ram        = {1'b0, we_q};
  assign S_oe_ram        = {1'b0, oe_q};
  assign S_addr_ram      = {{ADDR_W{1'b0}}, addr_q};
  assign S_Wdata_ram     = {{DATA_W{1'b0}}, wdata_q};
  assign S_data_ram_size = {{SIZE_W{1'b0}}, size_q};
  assign out_data        = rdata_q;
  assign out_last        = out_valid && is_last;
  assign start_port      = (state == S_START);
  assign cycles          = cycles_q;
  assign sorted_err      = err_q;
  assign timeout         = timeout_q;
  assign busy            = (state != S_IDLE);
  assign state_dbg       = state;

endmodule

// File: tb/tb_sort_accel_slave_driver.sv
// Bench for sort_accel_slave_driver: slave memory and accelerator models plus an output
// scoreboard; directed runs cover sorted/unsorted results, stalls, timeout and mid-run reset.
module tb_sort_accel_slave_driver;
  localparam int N  = 32;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int SW = 4;
  localparam int TO = 100;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              in_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic              out_last;
  logic              out_ready = 1'b0;
  logic [1:0]        S_oe_ram, S_we_ram;
  logic [2*AW-1:0]   S_addr_ram;
  logic [2*DW-1:0]   S_Wdata_ram;
  logic [2*SW-1:0]   S_data_ram_size;
  logic [2*DW-1:0]   Sout_Rdata_ram = '0;
  logic [1:0]        Sout_DataRdy = '0;
  logic              start_port;
  logic              done_port = 1'b0;
  logic [31:0]       cycles;
  logic              sorted_err, timeout, busy;
  logic [3:0]        state_dbg;

  sort_accel_slave_driver #(
    .N_ELEM(N), .ADDR_W(AW), .DATA_W(DW), .SIZE_W(SW), .BASE_ADDR(0), .TIMEOUT_CYC(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
    .S_oe_ram(S_oe_ram), .S_we_ram(S_we_ram), .S_addr_ram(S_addr_ram),
    .S_Wdata_ram(S_Wdata_ram), .S_data_ram_size(S_data_ram_size),
    .Sout_Rdata_ram(Sout_Rdata_ram), .Sout_DataRdy(Sout_DataRdy),
    .start_port(start_port), .done_port(done_port),
    .cycles(cycles), .sorted_err(sorted_err), .timeout(timeout), .busy(busy),
    .state_dbg(state_dbg)
  );

  // scoreboard state
  int             n_cmp = 0;
  int             n_err = 0;
  logic [DW:0]    exp_q[$];          // {last, data}
  logic [AW+DW-1:0] exp_wr_q[$];     // {addr, data}
  logic [DW-1:0]  rd_mem [0:127];
  int             we_cnt = 0, oe_cnt = 0, start_cnt = 0, out_cnt = 0, rd_expect = 0;
  bit             acc_en = 1'b1, stall = 1'b0, exp_err = 1'b0;
  logic [DW-1:0]  mon_prev = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // slave memory model: write latency 1, read latency 2; upper read field is junk
  int             wr_cd = 0, rd_cd = 0;
  logic [AW-1:0]  rd_addr = '0;
  logic           prev_we = 1'b0, prev_oe = 1'b0;
  logic [AW+DW-1:0] wr_e;
  always @(negedge clock) begin
    if (reset) begin
      Sout_DataRdy = 2'b00; wr_cd = 0; rd_cd = 0; prev_we = 1'b0; prev_oe = 1'b0;
    end else begin
      Sout_DataRdy = 2'b00;
      if (wr_cd > 0) begin wr_cd--; if (wr_cd == 0) Sout_DataRdy = 2'b01; end
      if (rd_cd > 0) begin
        rd_cd--;
        if (rd_cd == 0) begin Sout_DataRdy = 2'b01; Sout_Rdata_ram = {8'hA5, rd_mem[rd_addr]}; end
      end
      if (S_we_ram[0]) begin
        we_cnt++;
        chk("we_width", 64'(prev_we), 64'd0);
        chk("ch1_zero_wr", 64'({S_we_ram[1], S_oe_ram[1]}), 64'd0);
        chk("wr_expected", 64'(exp_wr_q.size() > 0), 64'd1);
        if (exp_wr_q.size() > 0) begin
          wr_e = exp_wr_q.pop_front();
          chk("wr_addr", 64'(S_addr_ram), 64'(wr_e[AW+DW-1:DW]));
          chk("wr_data", 64'(S_Wdata_ram), 64'(wr_e[DW-1:0]));
          chk("wr_size", 64'(S_data_ram_size), 64'(DW));
        end
        wr_cd = 1;
      end
      if (S_oe_ram[0]) begin
        oe_cnt++;
        chk("oe_width", 64'(prev_oe), 64'd0);
        chk("rd_addr", 64'(S_addr_ram), 64'(rd_expect));
        chk("rd_size", 64'(S_data_ram_size), 64'(DW));
        rd_expect++;
        rd_addr = S_addr_ram[AW-1:0];
        rd_cd = 2;
      end
      prev_we = S_we_ram[0];
      prev_oe = S_oe_ram[0];
    end
  end

  // accelerator model: done_port pulses 10 cycles after start when enabled
  int   acc_cd = 0;
  logic prev_start = 1'b0;
  always @(negedge clock) begin
    if (reset) begin
      done_port = 1'b0; acc_cd = 0; prev_start = 1'b0;
    end else begin
      done_port = 1'b0;
      if (acc_cd > 0) begin acc_cd--; if (acc_cd == 0 && acc_en) done_port = 1'b1; end
      if (start_port) begin
        start_cnt++;
        chk("start_width", 64'(prev_start), 64'd0);
        acc_cd = 10;
      end
      prev_start = start_port;
    end
  end

  // output consumer + monitor
  logic          held = 1'b0;
  logic [DW-1:0] held_data = '0;
  logic [DW:0]   mon_e;
  always @(negedge clock) begin
    if (reset) begin
      out_ready = 1'b0; held = 1'b0;
    end else begin
      out_ready = stall ? ~out_ready : 1'b1;
      if (held && out_valid) chk("out_stable", 64'(out_data), 64'(held_data));
      if (out_valid && out_ready) begin
        chk("out_expected", 64'(exp_q.size() > 0), 64'd1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("out_data", 64'(out_data), 64'(mon_e[DW-1:0]));
          chk("out_last", 64'(out_last), 64'(mon_e[DW]));
          chk("sorted_err_progress", 64'(sorted_err), 64'(exp_err));
          if (out_cnt > 0 && mon_e[DW-1:0] < mon_prev) exp_err = 1'b1;
          mon_prev = mon_e[DW-1:0];
        end
        out_cnt++;
        held = 1'b0;
      end else begin
        held = out_valid;
        held_data = out_data;
      end
    end
  end

  // driver tasks
  task automatic send(input logic [DW-1:0] d, input int gap);
    int t = 0;
    repeat (gap) @(negedge clock);
    while (!in_ready && t < 200) begin @(negedge clock); t++; end
    chk("in_ready_wait", 64'(t < 200), 64'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 5000) begin @(negedge clock); t++; end
    chk("idle_reached", 64'(t < 5000), 64'd1);
  endtask

  task automatic clear_run_counters();
    we_cnt = 0; oe_cnt = 0; start_cnt = 0; out_cnt = 0; rd_expect = 0;
    exp_err = 1'b0; mon_prev = '0;
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_last", 64'(out_last), 64'd0);
    chk("rst_start", 64'(start_port), 64'd0);
    chk("rst_we_oe", 64'({S_we_ram, S_oe_ram}), 64'd0);
    chk("rst_addr", 64'(S_addr_ram), 64'd0);
    chk("rst_wdata", 64'(S_Wdata_ram), 64'd0);
    chk("rst_size", 64'(S_data_ram_size), 64'd0);
    chk("rst_cycles", 64'(cycles), 64'd0);
    chk("rst_flags", 64'({sorted_err, timeout}), 64'd0);
  endtask

  // one full load/run/readback; inputs are N-1..0, memory returns 0..N-1 (optionally corrupted)
  task automatic run_full(input bit corrupt, input bit gaps, input bit stl, input bit acc_on);
    logic [DW-1:0] d;
    for (int i = 0; i < 128; i++) rd_mem[i] = 8'(i);
    if (corrupt) rd_mem[16] = 8'd3;
    stall  = stl;
    acc_en = acc_on;
    clear_run_counters();
    if (acc_on)
      for (int i = 0; i < N; i++) exp_q.push_back({(i == N - 1), rd_mem[i]});
    for (int i = 0; i < N; i++) begin
      d = 8'(N - 1 - i);
      exp_wr_q.push_back({7'(i), d});
      send(d, gaps ? int'($urandom_range(0, 3)) : 0);
    end
    wait_idle();
    repeat (3) @(negedge clock);
    chk("sorted_err", 64'(sorted_err), 64'(corrupt));
    chk("cycles", 64'(cycles), acc_on ? 64'd10 : 64'(TO));
    chk("timeout", 64'(timeout), 64'(!acc_on));
    chk("busy_end", 64'(busy), 64'd0);
    chk("start_count", 64'(start_cnt), 64'd1);
    chk("write_count", 64'(we_cnt), 64'(N));
    chk("read_count", 64'(oe_cnt), acc_on ? 64'(N) : 64'd0);
    chk("out_count", 64'(out_cnt), acc_on ? 64'(N) : 64'd0);
    chk("out_queue_drained", 64'(exp_q.size()), 64'd0);
    chk("wr_queue_drained", 64'(exp_wr_q.size()), 64'd0);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs();

    run_full(1'b0, 1'b0, 1'b0, 1'b1);   // sorted result, no stalls
    run_full(1'b1, 1'b1, 1'b1, 1'b1);   // element 16 out of order, gapped input, stalled output
    run_full(1'b0, 1'b0, 1'b0, 1'b0);   // accelerator never finishes

    // reset during WR_WAIT of idx 5
    stall = 1'b0; acc_en = 1'b1;
    clear_run_counters();
    for (int i = 0; i < 6; i++) begin
      exp_wr_q.push_back({7'(i), 8'(100 + i)});
      send(8'(100 + i), 0);
    end
    @(negedge clock);
    chk("pre_reset_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clock);
    check_reset_outputs();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (20) @(negedge clock);
    chk("abort_no_start", 64'(start_cnt), 64'd0);
    chk("abort_writes", 64'(we_cnt), 64'd6);
    chk("abort_no_reads", 64'(oe_cnt), 64'd0);
    chk("abort_idle", 64'(busy), 64'd0);
    chk("abort_wr_queue", 64'(exp_wr_q.size()), 64'd0);

    run_full(1'b0, 1'b0, 1'b0, 1'b1);   // fresh run after abort

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (compared %0d, mismatched %0d)", n_cmp, n_err);
    $fatal(1, "watchdog expired");
  end

endmodule
